// File: rtl/wave_pc_table_pkg.sv
// Shared definitions for the per-SIMD wave PC table: SIMD controller state
// encodings, default slot count and the per-cycle PC update operations.
package wave_pc_table_pkg;

  localparam int DEFAULT_NUM_WAVES = 4;
  localparam int DEFAULT_PC_WIDTH  = 32;

  typedef enum logic [2:0] {
    SIMD_IDLE      = 3'd0,
    SIMD_FETCH     = 3'd1,
    SIMD_DECODE    = 3'd2,
    SIMD_EXECUTE   = 3'd3,
    SIMD_WRITEBACK = 3'd4
  } simd_state_e;

  typedef enum logic [1:0] {
    OP_NONE   = 2'd0,
    OP_STEP   = 2'd1,
    OP_BRANCH = 2'd2,
    OP_RETIRE = 2'd3
  } wave_op_e;

endpackage

// File: rtl/wave_pc_table_rr_next_valid.sv
// Circular priority finder: first set bit of mask scanning start, start+1, ...
// wrapping modulo N.
module rr_next_valid #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand_s;

  // Walk every slot once from start; the first hit wins.
  always_comb begin
    found  = 1'b0;
    idx    = {IW{1'b0}};
    cand_s = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      cand_s = IW'((int'(start) + i) % N);
      if (!found && mask[cand_s]) begin
        found = 1'b1;
        idx   = cand_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/wave_pc_table.sv
// Per-SIMD table of resident wave PCs with round-robin selection of the wave
// that drives fetch; handles dispatch allocation, step/branch/retire.
module wave_pc_table
  import wave_pc_table_pkg::*;
#(
  parameter int  PROGRAM_MEM_ADDR_WIDTH = DEFAULT_PC_WIDTH,
  parameter int  NUM_WAVES              = DEFAULT_NUM_WAVES,
  localparam int WAVE_ID_WIDTH          = $clog2(NUM_WAVES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [2:0]                        simd_state,
  input  logic                              dispatch_valid,
  input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] dispatch_start_pc,
  output logic                              dispatch_ready,
  output logic [WAVE_ID_WIDTH-1:0]          dispatch_wave_id,
  input  logic                              branch_taken,
  input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] branch_target,
  input  logic                              wave_done,
  output logic                              cur_valid,
  output logic [WAVE_ID_WIDTH-1:0]          cur_wave_id,
  output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] cur_pc,
  output logic [NUM_WAVES-1:0]              active_mask
);

  localparam int W  = PROGRAM_MEM_ADDR_WIDTH;
  localparam int IW = WAVE_ID_WIDTH;

  logic [NUM_WAVES-1:0] valid_r;
  logic [NUM_WAVES-1:0] valid_next_s;
  logic [W-1:0]         pc_r [NUM_WAVES];
  logic [IW-1:0]        ptr_r;
  logic [IW-1:0]        ptr_next_s;
  logic [IW-1:0]        ptr_start_s;
  logic [IW-1:0]        free_idx_s;
  logic [IW-1:0]        next_idx_s;
  logic                 free_found_s;
  logic                 next_found_s;
  logic                 accept_s;
  logic                 exec_s;
  wave_op_e             op_s;

  assign cur_valid        = valid_r[ptr_r];
  assign cur_wave_id      = ptr_r;
  assign cur_pc           = pc_r[ptr_r];
  assign active_mask      = valid_r;
  assign dispatch_ready   = enable & ~rst & free_found_s;
  assign dispatch_wave_id = free_idx_s;
  assign accept_s         = dispatch_valid & dispatch_ready;
  assign exec_s           = enable & (simd_state == 3'(SIMD_EXECUTE)) & cur_valid;
  assign ptr_start_s      = (ptr_r == IW'(NUM_WAVES - 1)) ? {IW{1'b0}} : ptr_r + IW'(1);

  // Lowest free slot: searching the inverted valid bits from slot 0.
  rr_next_valid #(.N(NUM_WAVES), .IW(IW)) u_free_find (
    .mask  (~valid_r),
    .start ({IW{1'b0}}),
    .found (free_found_s),
    .idx   (free_idx_s)
  );

  // Next live wave after the current one; current slot is checked last.
  rr_next_valid #(.N(NUM_WAVES), .IW(IW)) u_next_find (
    .mask  (valid_next_s),
    .start (ptr_start_s),
    .found (next_found_s),
    .idx   (next_idx_s)
  );

  // Decode what happens to the selected wave this cycle; retire beats branch.
  always_comb begin
    op_s = OP_NONE;
    if (exec_s) begin
      if (wave_done) begin
        op_s = OP_RETIRE;
      end else if (branch_taken) begin
        op_s = OP_BRANCH;
      end else begin
        op_s = OP_STEP;
      end
    end else begin
      op_s = OP_NONE;
    end
  end

  // Post-update valid bits: this cycle's retire and dispatch folded in.
  always_comb begin
    valid_next_s = valid_r;
    if (op_s == OP_RETIRE) begin
      valid_next_s[ptr_r] = 1'b0;
    end else begin
      valid_next_s = valid_next_s;
    end
    if (accept_s) begin
      valid_next_s[free_idx_s] = 1'b1;
    end else begin
      valid_next_s = valid_next_s;
    end
  end

  // Pointer moves on execute cycles, or jumps to a new wave when idle.
  always_comb begin
    ptr_next_s = ptr_r;
    if (exec_s) begin
      if (next_found_s) begin
        ptr_next_s = next_idx_s;
      end else begin
        ptr_next_s = ptr_r;
      end
    end else if (!cur_valid && accept_s) begin
      ptr_next_s = free_idx_s;
    end else begin
      ptr_next_s = ptr_r;
    end
  end

  // State registers: valid bits, pointer and PC array.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {NUM_WAVES{1'b0}};
      ptr_r   <= {IW{1'b0}};
      for (int i = 0; i < NUM_WAVES; i++) begin
        pc_r[i] <= {W{1'b0}};
      end
    end else begin
      valid_r <= valid_next_s;
      ptr_r   <= ptr_next_s;
      case (op_s)
        OP_BRANCH: pc_r[ptr_r] <= branch_target;
        OP_STEP:   pc_r[ptr_r] <= pc_r[ptr_r] + {{(W-1){1'b0}}, 1'b1};
        default:   pc_r[ptr_r] <= pc_r[ptr_r];
      endcase
      // Dispatch never targets the executing slot, so both writes can coexist.
      if (accept_s) begin
        pc_r[free_idx_s] <= dispatch_start_pc;
      end
    end
  end

endmodule

// File: tb/tb_wave_pc_table.sv
// Directed bench for wave_pc_table: a reference model pushes expected
// post-edge outputs to a scoreboard queue that is popped after each edge.
module tb_wave_pc_table;
  import wave_pc_table_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [2:0]    simd_state;
  logic          dispatch_valid;
  logic [W-1:0]  dispatch_start_pc;
  logic          dispatch_ready;
  logic [IW-1:0] dispatch_wave_id;
  logic          branch_taken;
  logic [W-1:0]  branch_target;
  logic          wave_done;
  logic          cur_valid;
  logic [IW-1:0] cur_wave_id;
  logic [W-1:0]  cur_pc;
  logic [N-1:0]  active_mask;

  always #5 clk = ~clk;

  wave_pc_table #(.PROGRAM_MEM_ADDR_WIDTH(W), .NUM_WAVES(N)) dut (
    .clk(clk), .rst(rst), .enable(enable), .simd_state(simd_state),
    .dispatch_valid(dispatch_valid), .dispatch_start_pc(dispatch_start_pc),
    .dispatch_ready(dispatch_ready), .dispatch_wave_id(dispatch_wave_id),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .wave_done(wave_done), .cur_valid(cur_valid), .cur_wave_id(cur_wave_id),
    .cur_pc(cur_pc), .active_mask(active_mask)
  );

  typedef struct packed {
    logic          cv;
    logic [IW-1:0] cid;
    logic [W-1:0]  pc;
    logic [N-1:0]  mask;
    logic          rdy;
    logic          free;
    logic [IW-1:0] did;
  } exp_t;

  exp_t         sbq[$];
  int           total = 0;
  int           bad = 0;
  bit           m_valid [N];
  logic [W-1:0] m_pc [N];
  int           m_ptr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    int  f;
    bit  fnd;
    bit  cv;
    bit  ex;
    bit  acc;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_pc[i] = '0; end
      m_ptr = 0;
      return;
    end
    fnd = 0; f = 0;
    for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) begin fnd = 1; f = i; end
    acc = dispatch_valid && enable && fnd;
    cv  = m_valid[m_ptr];
    ex  = enable && (simd_state == 3'(SIMD_EXECUTE)) && cv;
    if (ex) begin
      if (wave_done) m_valid[m_ptr] = 0;
      else if (branch_taken) m_pc[m_ptr] = branch_target;
      else m_pc[m_ptr] = m_pc[m_ptr] + 32'd1;
    end
    if (acc) begin m_valid[f] = 1; m_pc[f] = dispatch_start_pc; end
    if (ex) begin
      for (int k = N; k >= 1; k--) if (m_valid[(m_ptr + k) % N]) f = (m_ptr + k) % N;
      for (int k = 1; k <= N; k++) if (m_valid[(m_ptr + k) % N]) begin m_ptr = (m_ptr + k) % N; break; end
    end else if (!cv && acc) begin
      m_ptr = f;
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.cv = m_valid[m_ptr];
    e.cid = IW'(m_ptr);
    e.pc = m_pc[m_ptr];
    e.free = 1'b0;
    e.did = '0;
    for (int i = 0; i < N; i++) begin
      e.mask[i] = m_valid[i];
      if (!m_valid[i] && !e.free) begin e.free = 1'b1; e.did = IW'(i); end
    end
    e.rdy = e.free && enable && !rst;
    sbq.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    model_edge();
    push_expect();
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, ".cur_valid"}, cur_valid, e.cv);
    chk({tag, ".cur_wave_id"}, cur_wave_id, e.cid);
    chk({tag, ".cur_pc"}, cur_pc, e.pc);
    chk({tag, ".active_mask"}, active_mask, e.mask);
    chk({tag, ".dispatch_ready"}, dispatch_ready, e.rdy);
    if (e.free) chk({tag, ".dispatch_wave_id"}, dispatch_wave_id, e.did);
  endtask

  task automatic drive(input logic [2:0] st, input logic dv, input logic [W-1:0] spc,
                       input logic bt, input logic [W-1:0] tgt, input logic wd);
    simd_state = st; dispatch_valid = dv; dispatch_start_pc = spc;
    branch_taken = bt; branch_target = tgt; wave_done = wd;
  endtask

  initial begin
    logic [IW-1:0] seq [6];
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd0; seq[4] = 2'd1; seq[5] = 2'd2;
    rst = 1'b1; enable = 1'b1;
    drive(3'(SIMD_IDLE), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("reset0");
    step("reset1");
    chk("reset.cur_pc", cur_pc, 32'h0);

    // First dispatch and sole-wave execution
    rst = 1'b0;
    drive(3'(SIMD_IDLE), 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    #1;
    chk("first.ready", dispatch_ready, 1'b1);
    chk("first.wave_id", dispatch_wave_id, 2'd0);
    step("first.disp");
    chk("first.pc", cur_pc, 32'h10);
    chk("first.mask", active_mask, 4'b0001);
    drive(3'(SIMD_EXECUTE), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("sole.exec");
    chk("sole.pc", cur_pc, 32'h11);
    chk("sole.id", cur_wave_id, 2'd0);

    // Three waves round robin
    rst = 1'b1; drive(3'(SIMD_IDLE), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("rst2");
    rst = 1'b0;
    drive(3'(SIMD_IDLE), 1'b1, 32'h100, 1'b0, 32'h0, 1'b0); step("rr.d0");
    drive(3'(SIMD_IDLE), 1'b1, 32'h200, 1'b0, 32'h0, 1'b0); step("rr.d1");
    drive(3'(SIMD_IDLE), 1'b1, 32'h300, 1'b0, 32'h0, 1'b0); step("rr.d2");
    drive(3'(SIMD_EXECUTE), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr.seq%0d", i), cur_wave_id, seq[i]);
      step("rr.exec");
    end
    drive(3'(SIMD_IDLE), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("rr.idle");
    chk("rr.pc0", cur_pc, 32'h102);

    // Fill, then retire slot 1 and reuse it
    drive(3'(SIMD_IDLE), 1'b1, 32'h400, 1'b0, 32'h0, 1'b0); step("fill.d3");
    chk("fill.ready", dispatch_ready, 1'b0);
    drive(3'(SIMD_EXECUTE), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); step("fill.exec0");
    drive(3'(SIMD_EXECUTE), 1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step("fill.retire1");
    chk("retire.ready", dispatch_ready, 1'b1);
    chk("retire.wave_id", dispatch_wave_id, 2'd1);
    drive(3'(SIMD_IDLE), 1'b1, 32'h500, 1'b0, 32'h0, 1'b0); step("reuse.d1");
    chk("reuse.mask", active_mask, 4'b1111);

    // Branch, then retire-with-branch on slot 2
    drive(3'(SIMD_EXECUTE), 1'b0, 32'h0, 1'b1, 32'h40, 1'b0); step("br.slot2");
    drive(3'(SIMD_EXECUTE), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("br.e3"); step("br.e0"); step("br.e1");
    chk("br.id", cur_wave_id, 2'd2);
    chk("br.pc", cur_pc, 32'h40);
    drive(3'(SIMD_EXECUTE), 1'b0, 32'h0, 1'b1, 32'h77, 1'b1); step("done.slot2");
    chk("done.mask", active_mask, 4'b1011);
    chk("done.id", cur_wave_id, 2'd3);

    // PC wrap on slot 3
    drive(3'(SIMD_EXECUTE), 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0); step("wrap.br");
    drive(3'(SIMD_EXECUTE), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("wrap.e0"); step("wrap.e1");
    chk("wrap.pre", cur_pc, 32'hFFFF_FFFF);
    step("wrap.step");
    chk("wrap.ptr", cur_wave_id, 2'd0);
    step("wrap.e0b"); step("wrap.e1b");
    chk("wrap.pc", cur_pc, 32'h0);

    // Enable low freezes everything
    enable = 1'b0;
    drive(3'(SIMD_EXECUTE), 1'b1, 32'h900, 1'b1, 32'h55, 1'b0);
    step("frz0"); step("frz1");
    chk("frz.id", cur_wave_id, 2'd3);
    chk("frz.pc", cur_pc, 32'h0);
    chk("frz.ready", dispatch_ready, 1'b0);

    // Reset with three live waves mid-execute
    enable = 1'b1; rst = 1'b1;
    drive(3'(SIMD_EXECUTE), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("midrst");
    chk("midrst.mask", active_mask, 4'b0000);
    chk("midrst.cv", cur_valid, 1'b0);
    chk("midrst.pc", cur_pc, 32'h0);
    chk("midrst.ready", dispatch_ready, 1'b0);

    // Idle pickup in execute state, then dispatch concurrent with execute
    rst = 1'b0;
    drive(3'(SIMD_EXECUTE), 1'b1, 32'hA0, 1'b0, 32'h0, 1'b0); step("pick.d0");
    drive(3'(SIMD_EXECUTE), 1'b1, 32'hB0, 1'b0, 32'h0, 1'b0); step("conc.d1");
    chk("conc.id", cur_wave_id, 2'd1);
    chk("conc.pc", cur_pc, 32'hB0);
    drive(3'(SIMD_EXECUTE), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); step("conc.e1");
    chk("conc.pc0", cur_pc, 32'hA1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_pc_table.md
# wave_pc_table

Per-SIMD program-counter table that tracks up to NUM_WAVES resident waves, replacing the single-wave PC. Each slot holds a valid bit and a PC. A round-robin pointer selects the wave whose PC drives instruction fetch. On every SIMD execute cycle the selected wave's PC advances, branches or retires. Sits between the wave dispatcher (slot allocation) and the SIMD fetch/execute controller.

## Interface
- PROGRAM_MEM_ADDR_WIDTH, 32: PC width; PC arithmetic wraps modulo 2^PROGRAM_MEM_ADDR_WIDTH.
- NUM_WAVES, 4: resident wave slots per SIMD; must be ≥2.
- WAVE_ID_WIDTH, $clog2(NUM_WAVES): slot index width (localparam).
- clk  in  1  clock; all state updates on posedge clk.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  global enable; low = freeze all state, dispatch_ready=0.
- simd_state  in  3  SIMD controller state; only `SIMD_EXECUTE` acts.
- dispatch_valid  in  1  new wave offered.
- dispatch_start_pc  in  PROGRAM_MEM_ADDR_WIDTH  initial PC of offered wave.
- dispatch_ready  out  1  a free slot exists (and enable, not rst).
- dispatch_wave_id  out  WAVE_ID_WIDTH  slot granted on handshake (lowest free index).
- branch_taken  in  1  current instruction redirects PC (sampled in execute).
- branch_target  in  PROGRAM_MEM_ADDR_WIDTH  absolute target PC.
- wave_done  in  1  current wave retires (sampled in execute; priority over branch).
- cur_valid  out  1  selected slot holds a live wave.
- cur_wave_id  out  WAVE_ID_WIDTH  selected slot.
- cur_pc  out  PROGRAM_MEM_ADDR_WIDTH  PC of selected slot.
- active_mask  out  NUM_WAVES  per-slot valid bits.

## Operation
- Reset: all valid=0, all PCs=0, pointer=0; outputs cur_valid=0, cur_wave_id=0, cur_pc=0, active_mask=0, dispatch_ready=0, dispatch_wave_id=0.
- Dispatch handshake: dispatch_valid & dispatch_ready accepts. Slot dispatch_wave_id gets valid=1, pc=dispatch_start_pc. Free-slot search uses registered valid bits. A slot freed by retire this cycle is allocatable next cycle.
- Execute (enable & simd_state==`SIMD_EXECUTE` & cur_valid), applied to slot cur_wave_id, in priority order:
  - wave_done → valid=0, PC unchanged.
  - else branch_taken → pc=branch_target.
  - else pc=pc+1, wrapping all-ones→0.
- Pointer advance, evaluated only on execute cycles: next = first slot with post-update valid=1 scanning cur+1, cur+2, … wrapping, current slot last. Post-update valid includes this cycle's retire and dispatch. Sole live wave → pointer stays.
- Idle pickup: cur_valid=0 and a dispatch accepted → pointer moves to that slot next cycle.
- No live waves → pointer holds, cur_valid=0.
- Non-execute states: PCs and pointer unchanged; dispatch still accepted.
- enable low: no updates of any kind; handshake cannot complete.
- branch_taken/wave_done ignored outside execute or when cur_valid=0.

## Timing
- cur_pc, cur_wave_id, cur_valid, active_mask: combinational from registers, zero latency. Updated value is visible the cycle after the execute/dispatch edge.
- dispatch_ready, dispatch_wave_id: combinational from registered valid bits. Ready drops the cycle after the last free slot fills.
- Dispatch plus execute in the same cycle target different slots by construction; both take effect.
- rst mid-operation: all slots dropped in one cycle, regardless of enable.
- One instruction per wave turn; fairness: with N live waves, each executes once per N execute cycles.

## Structure
- `common_defs.v`: existing SIMD state encodings (`SIMD_EXECUTE`). Add `DEFAULT_NUM_WAVES`.
- Sub-module rr_next_valid: parametrised circular priority finder. Inputs: mask and start index. Outputs: found flag and index. Instantiated once for pointer advance. Lowest-free allocation is a second instance with start index 0 on the inverted mask.
- PC storage: register array, no RAM.

## Test plan
- Reset then dispatch start_pc=0x10: dispatch_wave_id=0; next cycle cur_valid=1, cur_wave_id=0, cur_pc=0x10, active_mask=4'b0001.
- Dispatch waves at 0x100/0x200/0x300, then 6 execute cycles: cur_wave_id sequence 0,1,2,0,1,2; PCs end at 0x102/0x202/0x302.
- Fill all 4 slots: dispatch_ready=0. Retire slot 1: ready=1 the following cycle and next dispatch granted slot 1.
- Execute with branch_taken=1, branch_target=0x40 and wave_done=0: that wave's PC=0x40. Repeat with wave_done=1: slot retires, PC untouched, pointer skips it.
- PC=0xFFFFFFFF executes without branch → 0x00000000. enable=0 during execute → no PC or pointer change.
- Assert rst with 3 live waves mid-execute: next cycle active_mask=0, cur_valid=0, cur_pc=0, dispatch_ready=0 while rst is held.
